// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Show-ahead FIFO with synchronous flush; pointers carry one extra wrap bit.
module sync_flush_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // Storage is not reset, so the head reads as zero while empty.
   assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch FSM with redirect/drain control feeding a flushable {pc, instr} queue.
import cpu_pkg::*;

module fetch_queue_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic                       imem_ack,
   input  logic [INSTR_W-1:0]         imem_rdata,
   output logic                       instr_valid,
   output logic [INSTR_W-1:0]         instr_out,
   output logic [ADDR_W-1:0]          pc_out,
   input  logic                       instr_ready,
   output logic [$clog2(DEPTH+1)-1:0] fq_count
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t      state, state_nx;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
   logic [ADDR_W-1:0] stale_addr, stale_addr_nx;
   logic [ADDR_W-1:0] redirect_aligned;
   logic              push, pop, q_empty, q_full, fills_on_push;
   fetch_entry_t      push_entry, head_entry;

   assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign pop              = instr_valid && instr_ready;
   assign fills_on_push    = (fq_count == CW'(DEPTH-1)) && !pop;
   assign push_entry       = '{pc: fetch_pc, instr: imem_rdata};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         stale_addr <= RESET_PC;
      end else begin
         state      <= state_nx;
         fetch_pc   <= fetch_pc_nx;
         stale_addr <= stale_addr_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      fetch_pc_nx   = fetch_pc;
      stale_addr_nx = stale_addr;
      push          = 1'b0;
      unique case (state)
         IDLE: begin
            if (redirect_valid) begin
               state_nx    = REQ;
               fetch_pc_nx = redirect_aligned;
            end else if (!q_full) begin
               state_nx = REQ;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               fetch_pc_nx = redirect_aligned;
               if (!imem_ack) begin
                  state_nx      = DRAIN;
                  stale_addr_nx = fetch_pc;
               end
            end else if (imem_ack) begin
               push        = 1'b1;
               fetch_pc_nx = fetch_pc + ADDR_W'(PC_STEP);
               if (fills_on_push) state_nx = IDLE;
            end
         end
         DRAIN: begin
            // A redirect that coincides with the draining ack ends the drain,
            // otherwise a second bogus request would be left outstanding.
            if (redirect_valid) begin
               fetch_pc_nx = redirect_aligned;
               if (imem_ack) state_nx = REQ;
            end else if (imem_ack) begin
               state_nx = q_full ? IDLE : REQ;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign imem_req  = (state == REQ) || (state == DRAIN);
   assign imem_addr = (state == DRAIN) ? stale_addr : fetch_pc;

   sync_flush_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .head  (head_entry),
      .count (fq_count),
      .empty (q_empty),
      .full  (q_full)
   );

   assign instr_valid = !q_empty;
   assign instr_out   = head_entry.instr;
   assign pc_out      = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed vector table plus hand-written reset/fill/redirect sequences for fetch_queue_unit.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_ready = 1'b0;
   logic [2:0]  fq_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h100)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .instr_ready    (instr_ready),
      .fq_count       (fq_count)
   );

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        ack;
      logic        rdy;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc;
      logic [2:0]  ecnt;
   } vec_t;

   vec_t vq[$];

   // Memory contents model: each word is its address xor a fixed tag.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic ack, input logic rdy, input logic ereq,
                              input logic [31:0] eaddr, input logic evalid,
                              input logic [31:0] epc, input logic [2:0] ecnt);
      vec_t t;
      t.rst = r; t.rv = rv; t.rpc = rpc; t.ack = ack; t.rdy = rdy;
      t.ereq = ereq; t.eaddr = eaddr; t.evalid = evalid; t.epc = epc; t.ecnt = ecnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      bit seen;

      //          rst rv rpc           ack rdy  req addr          vld pc            cnt
      vq.push_back(v(1, 0, 32'h0,        0, 0,   0, 32'h100,       0, 32'h0,        0));
      // streaming with ready=1, ack one cycle after req
      vq.push_back(v(0, 0, 32'h0,        0, 1,   0, 32'h100,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   1, 32'h100,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 1,   1, 32'h100,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 1,   1, 32'h104,       1, 32'h100,      1));
      vq.push_back(v(0, 0, 32'h0,        1, 1,   1, 32'h108,       1, 32'h104,      1));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   1, 32'h10C,       1, 32'h108,      1));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   1, 32'h10C,       0, 32'h0,        0));
      // reset mid-REQ with ack present
      vq.push_back(v(1, 0, 32'h0,        1, 0,   0, 32'h100,       0, 32'h0,        0));
      // ready=0: fill to DEPTH, stray ack in IDLE ignored
      vq.push_back(v(0, 0, 32'h0,        1, 0,   0, 32'h100,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   1, 32'h100,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h100,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h104,       1, 32'h100,      1));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h108,       1, 32'h100,      2));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h10C,       1, 32'h100,      3));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   0, 32'h110,       1, 32'h100,      4));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   0, 32'h110,       1, 32'h100,      4));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   0, 32'h110,       1, 32'h104,      3));
      // resume at 0x110; push+pop at count 2
      vq.push_back(v(0, 0, 32'h0,        1, 1,   1, 32'h110,       1, 32'h108,      2));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   1, 32'h114,       1, 32'h10C,      2));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   1, 32'h114,       1, 32'h10C,      2));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   1, 32'h114,       1, 32'h110,      1));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   1, 32'h114,       0, 32'h0,        0));
      // redirect with pending req, second redirect while draining, ack 3 cycles later
      vq.push_back(v(0, 1, 32'h400,      0, 0,   1, 32'h114,       0, 32'h0,        0));
      vq.push_back(v(0, 1, 32'h800,      0, 0,   1, 32'h114,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   1, 32'h114,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h114,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h800,       0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h804,       1, 32'h800,      1));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   1, 32'h808,       1, 32'h800,      2));
      // redirect same cycle as ack (unaligned target), then wrap past 2^32
      vq.push_back(v(0, 1, 32'hFFFF_FFFD, 1, 1,  1, 32'h808,       1, 32'h800,      2));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'hFFFF_FFFC, 0, 32'h0,        0));
      vq.push_back(v(0, 0, 32'h0,        1, 0,   1, 32'h0,         1, 32'hFFFF_FFFC, 1));
      vq.push_back(v(0, 0, 32'h0,        0, 1,   1, 32'h4,         1, 32'hFFFF_FFFC, 2));
      vq.push_back(v(0, 0, 32'h0,        0, 0,   1, 32'h4,         1, 32'h0,        1));

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst            = vq[i].rst;
         redirect_valid = vq[i].rv;
         redirect_pc    = vq[i].rpc;
         imem_ack       = vq[i].ack;
         imem_rdata     = mem_word(vq[i].eaddr);
         instr_ready    = vq[i].rdy;
         #1;
         chk($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vq[i].ereq});
         chk($sformatf("v%0d_addr", i),  imem_addr,            vq[i].eaddr);
         chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vq[i].evalid});
         chk($sformatf("v%0d_count", i), {29'b0, fq_count},    {29'b0, vq[i].ecnt});
         if (vq[i].evalid) begin
            chk($sformatf("v%0d_pc", i),    pc_out,    vq[i].epc);
            chk($sformatf("v%0d_instr", i), instr_out, mem_word(vq[i].epc));
         end
      end

      // reset with a late ack present: outputs clear immediately
      @(negedge clk);
      rst = 1'b1; imem_ack = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
      #1;
      chk("rst_req",   {31'b0, imem_req},    32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_pc",    pc_out,               32'h0);
      chk("rst_instr", instr_out,            32'h0);
      chk("rst_addr",  imem_addr,            32'h100);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;

      // bounded wait for the first request after reset
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         #1;
         if (imem_req) seen = 1'b1;
         else @(negedge clk);
      end
      chk("first_req_seen", {31'b0, seen}, 32'h1);
      chk("first_req_addr", imem_addr,     32'h100);

      // fill the queue with ready held low
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         #1;
         if (fq_count == 3'd4) begin
            seen = 1'b1;
            imem_ack = 1'b0;
         end else begin
            imem_ack   = imem_req;
            imem_rdata = mem_word(imem_addr);
            @(negedge clk);
         end
      end
      chk("fill_done",  {31'b0, seen},     32'h1);
      chk("fill_req",   {31'b0, imem_req}, 32'h0);
      chk("fill_head",  pc_out,            32'h100);

      // redirect while IDLE with a full queue
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("idle_redir_count", {29'b0, fq_count},    32'h0);
      chk("idle_redir_valid", {31'b0, instr_valid}, 32'h0);
      chk("idle_redir_req",   {31'b0, imem_req},    32'h1);
      chk("idle_redir_addr",  imem_addr,            32'h200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
